// File: rtl/sim_ctrl.sv
// sim_ctrl: simulation controller sitting between the bench clock/reset and
// the CPU core. Stretches the external reset into core_rst, snoops the
// core's data-store bus for the riscv-tests tohost write and reports
// pass / fail(test number) / watchdog timeout with cycle and instret counts.
//
// Optional feature macro: SIM_CTRL_PERF_EN
//   defined   -> instret_cnt counts retirements while running
//   undefined -> instret_cnt is tied to zero and retire_valid is unused
module sim_ctrl #(
    parameter int                ADDR_W         = 32,
    parameter int                DATA_W         = 32,
    parameter int                CNT_W          = 32,
    parameter logic [ADDR_W-1:0] TOHOST_ADDR    = 32'h8000_1000,
    parameter int                RST_CYCLES     = 10,
    parameter int                TIMEOUT_CYCLES = 100,
    parameter int                HALT_ON_DONE   = 1
) (
    input  logic              clk,
    input  logic              rst,
    output logic              core_rst,
    input  logic              store_valid,
    input  logic [ADDR_W-1:0] store_addr,
    input  logic [DATA_W-1:0] store_data,
    input  logic              retire_valid,
    output logic              done,
    output logic              pass,
    output logic [DATA_W-1:0] fail_code,
    output logic              timeout,
    output logic [CNT_W-1:0]  cycle_cnt,
    output logic [CNT_W-1:0]  instret_cnt
);

    // Reset-stretch counter only needs to hold RST_CYCLES (which is >= 1).
    localparam int                RC_W     = $clog2(RST_CYCLES + 1);
    localparam logic [RC_W-1:0]   RC_LOAD  = RC_W'(RST_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  TO_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic              WD_EN    = (TIMEOUT_CYCLES != 0) ? 1'b1 : 1'b0;
    localparam logic              HALT_S   = (HALT_ON_DONE != 0) ? 1'b1 : 1'b0;
    localparam logic [DATA_W-1:0] DATA_ONE = {{(DATA_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ST_RESET   = 3'd0,
        ST_RUN     = 3'd1,
        ST_PASS    = 3'd2,
        ST_FAIL    = 3'd3,
        ST_TIMEOUT = 3'd4
    } state_t;

    state_t            state_r,     state_nx_s;
    logic [RC_W-1:0]   rst_cnt_r,   rst_cnt_nx_s;
    logic [CNT_W-1:0]  cycle_r,     cycle_nx_s;
    logic              core_rst_r,  core_rst_nx_s;
    logic              done_r,      done_nx_s;
    logic              pass_r,      pass_nx_s;
    logic [DATA_W-1:0] fail_code_r, fail_code_nx_s;
    logic              timeout_r,   timeout_nx_s;

    logic              tohost_hit_s;
    logic [CNT_W-1:0]  cycle_inc_s;

    assign tohost_hit_s = store_valid && (store_addr == TOHOST_ADDR);
    assign cycle_inc_s  = (cycle_r == CNT_MAX) ? cycle_r : (cycle_r + CNT_W'(1));

    // Next-state and next-output decode; terminal states simply hold.
    always_comb begin
        state_nx_s     = state_r;
        rst_cnt_nx_s   = rst_cnt_r;
        cycle_nx_s     = cycle_r;
        core_rst_nx_s  = core_rst_r;
        done_nx_s      = done_r;
        pass_nx_s      = pass_r;
        fail_code_nx_s = fail_code_r;
        timeout_nx_s   = timeout_r;
        case (state_r)
            ST_RESET: begin
                if (rst_cnt_r <= RC_W'(1)) begin
                    state_nx_s    = ST_RUN;
                    rst_cnt_nx_s  = {RC_W{1'b0}};
                    core_rst_nx_s = 1'b0;
                end else begin
                    rst_cnt_nx_s  = rst_cnt_r - RC_W'(1);
                end
            end
            ST_RUN: begin
                // The cycle that sees the terminal event is still counted.
                cycle_nx_s = cycle_inc_s;
                if (tohost_hit_s && (store_data == DATA_ONE)) begin
                    state_nx_s    = ST_PASS;
                    done_nx_s     = 1'b1;
                    pass_nx_s     = 1'b1;
                    core_rst_nx_s = HALT_S;
                end else if (tohost_hit_s && store_data[0]) begin
                    state_nx_s     = ST_FAIL;
                    done_nx_s      = 1'b1;
                    fail_code_nx_s = {1'b0, store_data[DATA_W-1:1]};
                    core_rst_nx_s  = HALT_S;
                end else if (WD_EN && (cycle_r == TO_LIMIT)) begin
                    state_nx_s    = ST_TIMEOUT;
                    done_nx_s     = 1'b1;
                    timeout_nx_s  = 1'b1;
                    core_rst_nx_s = HALT_S;
                end else begin
                    state_nx_s    = ST_RUN;
                end
            end
            ST_PASS, ST_FAIL, ST_TIMEOUT: begin
                state_nx_s = state_r;
            end
            default: begin
                state_nx_s     = ST_RESET;
                rst_cnt_nx_s   = RC_LOAD;
                cycle_nx_s     = {CNT_W{1'b0}};
                core_rst_nx_s  = 1'b1;
                done_nx_s      = 1'b0;
                pass_nx_s      = 1'b0;
                fail_code_nx_s = {DATA_W{1'b0}};
                timeout_nx_s   = 1'b0;
            end
        endcase
    end

    // State and registered outputs; rst overrides everything on the next edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_RESET;
            rst_cnt_r   <= RC_LOAD;
            cycle_r     <= {CNT_W{1'b0}};
            core_rst_r  <= 1'b1;
            done_r      <= 1'b0;
            pass_r      <= 1'b0;
            fail_code_r <= {DATA_W{1'b0}};
            timeout_r   <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            rst_cnt_r   <= rst_cnt_nx_s;
            cycle_r     <= cycle_nx_s;
            core_rst_r  <= core_rst_nx_s;
            done_r      <= done_nx_s;
            pass_r      <= pass_nx_s;
            fail_code_r <= fail_code_nx_s;
            timeout_r   <= timeout_nx_s;
        end
    end

    assign core_rst  = core_rst_r;
    assign done      = done_r;
    assign pass      = pass_r;
    assign fail_code = fail_code_r;
    assign timeout   = timeout_r;
    assign cycle_cnt = cycle_r;

`ifdef SIM_CTRL_PERF_EN
    logic [CNT_W-1:0] instret_r;

    // Retired-instruction counter: counts only while running, saturating.
    always_ff @(posedge clk) begin
        if (rst) begin
            instret_r <= {CNT_W{1'b0}};
        end else if ((state_r == ST_RUN) && retire_valid && (instret_r != CNT_MAX)) begin
            instret_r <= instret_r + CNT_W'(1);
        end else begin
            instret_r <= instret_r;
        end
    end

    assign instret_cnt = instret_r;
`else
    logic unused_retire_s;
    assign unused_retire_s = retire_valid;
    assign instret_cnt     = {CNT_W{1'b0}};
`endif

endmodule

// File: doc/sim_ctrl.md
# sim_ctrl

Synthesizable simulation controller between the testbench clock/reset sources and the CPU `top`. It stretches the external reset into a parametrised core reset and snoops the core's data-store bus for the riscv-tests `tohost` write. It reports pass, fail (with test number) or watchdog timeout, and keeps cycle and retired-instruction counts. It replaces fixed-delay `#200`/`#2000` sequencing with a cycle-accurate, self-checking end-of-test condition.

## Interface
- `ADDR_W`, 32, store address width
- `DATA_W`, 32, store data width
- `CNT_W`, 32, width of cycle/instret counters
- `TOHOST_ADDR`, 32'h8000_1000, address of the `tohost` word
- `RST_CYCLES`, 10, core-reset stretch in cycles after `rst` drops; must be ≥1
- `TIMEOUT_CYCLES`, 100, watchdog limit in RUN cycles; 0 disables the watchdog
- `HALT_ON_DONE`, 1, when 1 re-assert `core_rst` in every terminal state

- `clk`  in  1  single clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `core_rst`  out  1  reset to `top`, active-high
- `store_valid`  in  1  core data store this cycle
- `store_addr`  in  ADDR_W  store address
- `store_data`  in  DATA_W  store data
- `retire_valid`  in  1  one instruction retired this cycle
- `done`  out  1  terminal state reached
- `pass`  out  1  test passed
- `fail_code`  out  DATA_W  failing test number (`store_data >> 1`); 0 unless FAIL
- `timeout`  out  1  watchdog expired
- `cycle_cnt`  out  CNT_W  cycles spent in RUN
- `instret_cnt`  out  CNT_W  instructions retired in RUN

## Operation
- States: RESET, RUN, PASS, FAIL, TIMEOUT. PASS, FAIL and TIMEOUT are terminal and sticky until `rst`.
- While `rst`=1: state RESET, reset counter loaded with RST_CYCLES, `core_rst`=1, all other outputs 0.
- RESET with `rst`=0: the counter decrements each cycle. On the edge where it goes from 1 to 0, enter RUN with `core_rst`=0.
- RUN: `cycle_cnt` increments each cycle and saturates at all-ones. `instret_cnt` increments on `retire_valid` and also saturates.
- A terminal store is `store_valid` && `store_addr`==TOHOST_ADDR, sampled only in RUN.
  - `store_data`==1: go to PASS.
  - `store_data[0]`==1, any other value: go to FAIL, with `fail_code` = `store_data` >> 1.
  - `store_data[0]`==0: ignored; stay in RUN.
- Watchdog: when TIMEOUT_CYCLES≠0, RUN and `cycle_cnt`==TIMEOUT_CYCLES-1 with no terminal store, go to TIMEOUT.
- Simultaneous terminal store and watchdog expiry: the store wins.
- Terminal states:
  - `done`=1, plus exactly one of `pass`, nonzero-or-zero `fail_code` with FAIL, or `timeout`.
  - Counters frozen.
  - `core_rst`=HALT_ON_DONE.
  - Further stores and retires are ignored.
- Stores outside RUN (RESET or terminal) are ignored.
- `rst` asserted in any state, including mid-run: on the next edge go to RESET with all outputs at reset values and the counters cleared.

## Timing
- All outputs are registered and update on the same edge as the state transition. There are no combinational paths from input to output.
- `core_rst` falls exactly RST_CYCLES rising edges after the first edge that samples `rst`=0.
- A terminal store sampled at edge N gives `done`/`pass`/`fail_code` valid after edge N. The `cycle_cnt` and `instret_cnt` values include cycle N and then freeze.
- Timeout is asserted after exactly TIMEOUT_CYCLES RUN cycles, at which point `cycle_cnt`==TIMEOUT_CYCLES.
- The first RUN cycle counts as `cycle_cnt`=1 after its edge. A `retire_valid` during RESET is not counted.

## Configuration
- `SIM_CTRL_PERF_EN`:
  - Defined: `instret_cnt` counter implemented as described.
  - Undefined: `instret_cnt` is tied to 0, `retire_valid` is unused, and no counter flops are generated. All other behaviour is unchanged.

## Test plan
- Reset stretch, RST_CYCLES=10: `rst`=1 for 5 cycles, then 0 → `core_rst` stays 1 for exactly 10 more edges and then falls. `done`=0 and counters are 0 throughout.
- Pass: store `8000_1000`←1 at RUN cycle 37 with retire every cycle → `done`=1, `pass`=1, `cycle_cnt`=37, `instret_cnt`=37 (0 without the macro), `core_rst`=1 next cycle.
- Fail: store `8000_1000`←`0x0000_0007` → `done`=1, `pass`=0, `fail_code`=3, `timeout`=0.
- Filtering:
  - store ←`0x0000_0004` to `8000_1000` → ignored, stays RUN.
  - store ←1 to `8000_1004` → ignored, stays RUN.
  - store ←1 during RESET → ignored, stays RESET.
- Watchdog, TIMEOUT_CYCLES=100: no store → `timeout`=1 and `cycle_cnt`=100. Second run: pass store on cycle 100 → `pass`=1 and `timeout`=0 (store wins).
- Mid-run reset: `rst` pulsed for 1 cycle at RUN cycle 50 → all outputs cleared next edge, `core_rst`=1, and a fresh 10-cycle stretch follows.
